// File: rtl/regfile_sc.sv
// regfile_sc: 32-entry 2R1W register file with $0 hardwired to zero and a post-reset clear sequencer
module regfile_sc #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int NREGS          = 2**ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic              wr_drop
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [NREGS];
    logic run;
    assign run  = state == RUN;
    assign busy = rst | ~run;
    always_comb state_nx = (state == CLEAR && clr_idx == ADDR_W'(NREGS-1)) ? RUN : state;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_idx <= ADDR_W'(1);
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_idx <= run ? clr_idx : clr_idx + 1'b1;
            wr_drop <= we & ~run;
        end
    end
    // entry 0 is never written; reads of index 0 are forced to zero instead
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) mem[clr_idx] <= '0;
            else if (we && waddr != '0) mem[waddr] <= wdata;
        end
    end
    assign rdata1 = (busy || !re1 || raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    assign rdata2 = (busy || !re2 || raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
endmodule
